// File: rtl/reg_bank_wr_arbiter.sv
// reg_bank_wr_arbiter
// Shares one WIDTH-bit enabled storage register among NUM_REQ requesters.
// A three-state sequencer (IDLE -> WRITE -> ACK) grants one writer at a time.
// The winner's data is captured into a holding register at grant. The shared
// register is written in WRITE, and the winner gets a one-cycle acknowledge in ACK.
// All outputs are decoded from registered state only, so there is no
// combinational path from iReq to any output.
//
// Build option:
//   REGARB_FIXED_PRIO_EN  when defined, the lowest set iReq index always wins
//                         and the round-robin pointer is frozen at zero.
//                         When undefined (default), arbitration is round-robin.

module reg_bank_wr_arbiter #(
    parameter int                NUM_REQ   = 4,
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RST_VALUE = '0
) (
    input  logic                       iClk,
    input  logic                       iRst_n,
    input  logic [NUM_REQ-1:0]         iReq,
    input  logic [NUM_REQ*WIDTH-1:0]   iData,
    output logic [NUM_REQ-1:0]         oGnt,
    output logic [NUM_REQ-1:0]         oAck,
    output logic                       oWrEna,
    output logic                       oBusy,
    output logic [WIDTH-1:0]           oQ
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t             stateReg, stateNext;
    logic [IDX_W-1:0]   winReg,   winNext;
    logic [IDX_W-1:0]   ptrReg,   ptrNext;
    logic [WIDTH-1:0]   holdReg,  holdNext;
    logic [WIDTH-1:0]   qReg,     qNext;

    logic [IDX_W-1:0]   pickIdx;
    logic               pickValid;
    logic [WIDTH-1:0]   dataArr [NUM_REQ];
    logic [NUM_REQ-1:0] winOneHot;

    // Split the flat data bus into one word per requester and decode the
    // latched winner index into a one-hot vector.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perReq
            assign dataArr[gi]   = iData[gi*WIDTH +: WIDTH];
            assign winOneHot[gi] = (winReg == IDX_W'(gi));
        end
    endgenerate

`ifdef REGARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top down so the lowest set index is the last
    // assignment and therefore wins.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (iReq[IDX_W'(k)]) begin
                pickValid = 1'b1;
                pickIdx   = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W:0] rrSum;

    // Round-robin: visit offsets from the pointer in descending order. The
    // smallest offset (closest at-or-after the pointer, wrapping) is then the
    // last one written and wins.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        rrSum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            rrSum = {1'b0, ptrReg} + (IDX_W+1)'(k);
            if (rrSum >= (IDX_W+1)'(NUM_REQ)) begin
                rrSum = rrSum - (IDX_W+1)'(NUM_REQ);
            end
            if (iReq[rrSum[IDX_W-1:0]]) begin
                pickValid = 1'b1;
                pickIdx   = rrSum[IDX_W-1:0];
            end
        end
    end
`endif

    // State and datapath registers. Reset aborts any transaction in flight.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            stateReg <= IDLE;
            winReg   <= '0;
            ptrReg   <= '0;
            holdReg  <= '0;
            qReg     <= RST_VALUE;
        end else begin
            stateReg <= stateNext;
            winReg   <= winNext;
            ptrReg   <= ptrNext;
            holdReg  <= holdNext;
            qReg     <= qNext;
        end
    end

    // Next-state logic. Grant and data capture happen on the IDLE edge, so later
    // changes on iReq or iData cannot alter the write already in progress.
    always_comb begin
        stateNext = stateReg;
        winNext   = winReg;
        ptrNext   = ptrReg;
        holdNext  = holdReg;
        qNext     = qReg;
        case (stateReg)
            IDLE: begin
                if (pickValid) begin
                    winNext   = pickIdx;
                    holdNext  = dataArr[pickIdx];
                    stateNext = WRITE;
                end
            end
            WRITE: begin
                qNext     = holdReg;
                stateNext = ACK;
            end
            ACK: begin
`ifndef REGARB_FIXED_PRIO_EN
                // The winner ranks last in the next arbitration round.
                ptrNext = (winReg == IDX_W'(NUM_REQ - 1)) ? '0 : winReg + IDX_W'(1);
`endif
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        oWrEna = (stateReg == WRITE);
        oBusy  = (stateReg == WRITE) || (stateReg == ACK);
        oGnt   = oBusy ? winOneHot : '0;
        oAck   = (stateReg == ACK) ? winOneHot : '0;
        oQ     = qReg;
    end

endmodule
